// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the fetch PC, talks to a variable-latency instruction memory over req/ready,
// and squashes wrong-path fetches when decode resolves a taken branch or jump.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        branchTakenD,
  input  logic [31:0] branchTargetD,
  input  logic        jumpD,
  input  logic [31:0] jumpTargetD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_buf_instr;
  logic        r_pend;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;

  logic        w_redir;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;

  // Redirect only counts for a real, non-stalled instruction in decode; jump wins over branch.
  assign w_redir  = r_valid_d & ~stallD & (jumpD | branchTakenD);
  assign w_tgt    = (jumpD ? jumpTargetD : branchTargetD) & ~32'h0000_0003;
  assign w_pc_inc = r_pc_f + 32'd4;

  assign imem_req  = (r_state == StFetch);
  assign imem_addr = r_pc_f;
  assign instrD    = r_instr_d;
  assign pcD       = r_pc_d;
  assign validD    = r_valid_d;

  // Fetch FSM, fetch PC, redirect bookkeeping and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_pc_f    <= RESET_PC;
      r_pend    <= 1'b0;
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'h0000_0000;
      r_valid_d <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_state <= StFetch;
          if (!stallD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
          end
        end
        StFetch: begin
          if (!imem_ready) begin
            // Remember the redirect; the in-flight request must still complete.
            if (w_redir) begin
              r_pend     <= 1'b1;
              r_pend_tgt <= w_tgt;
            end
            if (!stallD) begin
              r_instr_d <= NOP_INSTR;
              r_valid_d <= 1'b0;
            end
          end else if (r_pend || w_redir) begin
            // Returning word is wrong-path: drop it and restart at the target.
            r_pc_f <= w_redir ? w_tgt : r_pend_tgt;
            r_pend <= 1'b0;
            if (!stallD) begin
              r_instr_d <= NOP_INSTR;
              r_valid_d <= 1'b0;
            end
          end else if (!stallD) begin
            r_instr_d <= imem_rdata;
            r_pc_d    <= r_pc_f;
            r_valid_d <= 1'b1;
            r_pc_f    <= w_pc_inc;
          end else begin
            // Decode is stalled: park the word until IF/ID can accept it.
            r_buf_instr <= imem_rdata;
            r_state     <= StHold;
          end
        end
        StHold: begin
          if (!stallD) begin
            if (w_redir) begin
              r_pc_f    <= w_tgt;
              r_instr_d <= NOP_INSTR;
              r_valid_d <= 1'b0;
            end else begin
              r_instr_d <= r_buf_instr;
              r_pc_d    <= r_pc_f;
              r_valid_d <= 1'b1;
              r_pc_f    <= w_pc_inc;
            end
            r_state <= StFetch;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by a randomized run checked by a
// program-order scoreboard over the instruction stream entering IF/ID.
module tb_if_stage;

  localparam logic [31:0] RstPc = 32'h0000_3000;
  localparam logic [31:0] Nop   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD;
  logic        branchTakenD;
  logic [31:0] branchTargetD;
  logic        jumpD;
  logic [31:0] jumpTargetD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stallD       (stallD),
    .branchTakenD (branchTakenD),
    .branchTargetD(branchTargetD),
    .jumpD        (jumpD),
    .jumpTargetD  (jumpTargetD),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instrD       (instrD),
    .pcD          (pcD),
    .validD       (validD)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample after the edge, and present the word at the current address.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, RstPc);
    chk({tag, "_valid"}, {31'd0, validD}, 32'd0);
    chk({tag, "_instr"}, instrD, Nop);
    chk({tag, "_pcd"},   pcD, 32'd0);
  endtask

  task automatic check_deliver(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, validD}, 32'd1);
    chk({tag, "_pcd"},   pcD, pc);
    chk({tag, "_instr"}, instrD, mem_word(pc));
  endtask

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  // Randomized-run scoreboard state
  logic [31:0] e_next;
  logic        exp_bubble;
  logic        was_stall;
  logic        was_wait;
  logic [31:0] snap_instr;
  logic [31:0] snap_pc;
  logic        snap_valid;
  logic [31:0] snap_addr;
  int          gap;

  initial begin
    rst           = 1'b0;
    stallD        = 1'b0;
    branchTakenD  = 1'b0;
    branchTargetD = 32'd0;
    jumpD         = 1'b0;
    jumpTargetD   = 32'd0;
    imem_ready    = 1'b1;
    imem_rdata    = 32'd0;

    // Reset, then zero-wait streaming
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b1;
    tick();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, RstPc);
    chk("t1_bubble", {31'd0, validD}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_deliver("t1_stream", RstPc + 32'(4 * k));
      chk("t1_next_addr", imem_addr, RstPc + 32'(4 * (k + 1)));
    end

    // Reset while a request is outstanding; late ready during reset is ignored
    imem_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    imem_ready = 1'b1;
    tick();
    check_reset_vals("t6_rst");
    rst = 1'b1;
    tick();
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr", imem_addr, RstPc);
    tick();
    check_deliver("t6_first", RstPc);

    // Two wait cycles per request
    rst        = 1'b0;
    imem_ready = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_addr_hold", imem_addr, RstPc);
      chk("t2_bubble", {31'd0, validD}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    check_deliver("t2_deliver", RstPc);

    // Decode stall while fetch of 0x3004 completes
    stallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_req", {31'd0, imem_req}, 32'd0);
      check_deliver("t3_hold_ifid", RstPc);
    end
    stallD = 1'b0;
    tick();
    check_deliver("t3_release", 32'h0000_3004);
    chk("t3_resume_addr", imem_addr, 32'h0000_3008);
    tick();
    check_deliver("t3_resume", 32'h0000_3008);

    // Branch resolved while fetch of 0x300C is waiting
    imem_ready    = 1'b0;
    branchTakenD  = 1'b1;
    branchTargetD = 32'h0000_3101;
    tick();
    chk("t4_squash", {31'd0, validD}, 32'd0);
    chk("t4_addr_hold", imem_addr, 32'h0000_300C);
    branchTakenD = 1'b0;
    imem_ready   = 1'b1;
    tick();
    chk("t4_drop", {31'd0, validD}, 32'd0);
    chk("t4_tgt_addr", imem_addr, 32'h0000_3100);
    tick();
    check_deliver("t4_target", 32'h0000_3100);

    // Jump and branch together, coincident with ready
    jumpD         = 1'b1;
    jumpTargetD   = 32'h0000_4002;
    branchTakenD  = 1'b1;
    branchTargetD = 32'h0000_5000;
    tick();
    chk("t5_bubble", {31'd0, validD}, 32'd0);
    chk("t5_nop", instrD, Nop);
    chk("t5_jump_addr", imem_addr, 32'h0000_4000);
    jumpD        = 1'b0;
    branchTakenD = 1'b0;
    tick();
    check_deliver("t5_target", 32'h0000_4000);

    // Randomized run against the program-order scoreboard
    rst = 1'b0;
    tick();
    rst        = 1'b1;
    e_next     = RstPc;
    exp_bubble = 1'b0;
    gap        = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stallD        = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 1) == 1);
      branchTakenD  = ($urandom_range(0, 3) == 0);
      jumpD         = ($urandom_range(0, 5) == 0);
      branchTargetD = pick_target();
      jumpTargetD   = pick_target();
      // Next instruction in program order after the one now in decode
      exp_bubble = 1'b0;
      if (validD && !stallD) begin
        if (jumpD || branchTakenD) begin
          e_next     = (jumpD ? jumpTargetD : branchTargetD) & 32'hFFFF_FFFC;
          exp_bubble = 1'b1;
        end else begin
          e_next = pcD + 32'd4;
        end
      end
      was_stall  = stallD;
      was_wait   = imem_req && !imem_ready;
      snap_instr = instrD;
      snap_pc    = pcD;
      snap_valid = validD;
      snap_addr  = imem_addr;
      tick();
      gap++;
      if (was_stall) begin
        chk("rnd_hold_valid", {31'd0, validD}, {31'd0, snap_valid});
        chk("rnd_hold_pc", pcD, snap_pc);
        chk("rnd_hold_instr", instrD, snap_instr);
      end else begin
        if (exp_bubble) chk("rnd_squash", {31'd0, validD}, 32'd0);
        if (validD) begin
          chk("rnd_seq_pc", pcD, e_next);
          chk("rnd_seq_instr", instrD, mem_word(pcD));
          gap = 0;
        end else begin
          chk("rnd_bubble_nop", instrD, Nop);
        end
      end
      if (was_wait) chk("rnd_addr_stable", imem_addr, snap_addr);
      if (gap > 200) begin
        chk("rnd_liveness_gap", 32'(gap), 32'd200);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
